// File: rtl/ascon_pkg.sv
// Shared definitions for the Ascon permutation core.
//   state_t      : 320-bit state, x0 in the top word down to x4 in the bottom word
//   X0..X4       : LSB offsets of each 64-bit word, used as s[Xn +: 64]
//   perm_state_e : FSM states of ascon_perm
//   perm_dbg_t   : debug view of the FSM (state, round index, current round constant)
//   ascon_rc()   : round constant for round index r
//   nr_legal()   : round-count check for a given unroll factor
package ascon_pkg;

   typedef logic [319:0] state_t;

   localparam int X0 = 256;
   localparam int X1 = 192;
   localparam int X2 = 128;
   localparam int X3 = 64;
   localparam int X4 = 0;

   localparam int ROUNDS_MAX = 12;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } perm_state_e;

   typedef struct packed {
      perm_state_e state;
      logic [3:0]  round;
      logic [63:0] rc;
   } perm_dbg_t;

   function automatic logic [63:0] ascon_rc(input logic [3:0] r);
      return {56'd0, 4'hF - r, r};
   endfunction

   // unroll is 1, 2 or 4, so "multiple of unroll" reduces to the low bits being zero.
   function automatic logic nr_legal(input logic [3:0] nr, input int unroll);
      logic [3:0] mask;
      mask = 4'(unroll - 1);
      return (nr != 4'd0) && (nr <= 4'(ROUNDS_MAX)) && ((nr & mask) == 4'd0);
   endfunction

endpackage

// File: rtl/ascon_pl.sv
// Ascon linear diffusion layer: each word is XORed with two rotations of itself.
//   s_i : state before diffusion
//   s_o : state after diffusion
module ascon_pl
   import ascon_pkg::*;
(
   input  state_t s_i,
   output state_t s_o
);

   function automatic logic [63:0] ror(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   assign s_o[X0 +: 64] = s_i[X0 +: 64] ^ ror(s_i[X0 +: 64], 19) ^ ror(s_i[X0 +: 64], 28);
   assign s_o[X1 +: 64] = s_i[X1 +: 64] ^ ror(s_i[X1 +: 64], 61) ^ ror(s_i[X1 +: 64], 39);
   assign s_o[X2 +: 64] = s_i[X2 +: 64] ^ ror(s_i[X2 +: 64], 1)  ^ ror(s_i[X2 +: 64], 6);
   assign s_o[X3 +: 64] = s_i[X3 +: 64] ^ ror(s_i[X3 +: 64], 10) ^ ror(s_i[X3 +: 64], 17);
   assign s_o[X4 +: 64] = s_i[X4 +: 64] ^ ror(s_i[X4 +: 64], 7)  ^ ror(s_i[X4 +: 64], 41);

endmodule

// File: rtl/ascon_ps.sv
// Ascon substitution layer: the 5-bit S-box applied bit-sliced to all 64
// columns of the five state words.
//   s_i : state before substitution
//   s_o : state after substitution
module ascon_ps
   import ascon_pkg::*;
(
   input  state_t s_i,
   output state_t s_o
);

   logic [63:0] a0, a1, a2, a3, a4;
   logic [63:0] t0, t1, t2, t3, t4;
   logic [63:0] b0, b1, b2, b3, b4;

   // Input mixing
   assign a0 = s_i[X0 +: 64] ^ s_i[X4 +: 64];
   assign a1 = s_i[X1 +: 64];
   assign a2 = s_i[X2 +: 64] ^ s_i[X1 +: 64];
   assign a3 = s_i[X3 +: 64];
   assign a4 = s_i[X4 +: 64] ^ s_i[X3 +: 64];

   // Chi-like nonlinear step
   assign t0 = ~a0 & a1;
   assign t1 = ~a1 & a2;
   assign t2 = ~a2 & a3;
   assign t3 = ~a3 & a4;
   assign t4 = ~a4 & a0;

   assign b0 = a0 ^ t1;
   assign b1 = a1 ^ t2;
   assign b2 = a2 ^ t3;
   assign b3 = a3 ^ t4;
   assign b4 = a4 ^ t0;

   // Output mixing
   assign s_o[X0 +: 64] = b0 ^ b4;
   assign s_o[X1 +: 64] = b1 ^ b0;
   assign s_o[X2 +: 64] = ~b2;
   assign s_o[X3 +: 64] = b3 ^ b2;
   assign s_o[X4 +: 64] = b4;

endmodule

// File: rtl/ascon_perm.sv
// Iterative Ascon permutation core, UNROLL rounds per clock.
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset
//   start_i : request, sampled only while idle
//   nr_i    : round count (1..12, multiple of UNROLL)
//   S_i     : input state
//   S_o     : state register (final state once done_o pulses)
//   busy_o  : permutation in progress
//   done_o  : one-cycle pulse, S_o holds the result
//   err_o   : one-cycle pulse, the request was rejected
//   dbg_o   : FSM state, round index and the constant of the first round this cycle
// Handshake: a request is taken on any rising edge where start_i=1 and busy_o=0;
// start_i is ignored while busy_o=1. There is no backpressure on the result.
module ascon_perm
   import ascon_pkg::*;
#(
   parameter int UNROLL = 1
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic [3:0] nr_i,
   input  state_t     S_i,
   output state_t     S_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       err_o,
   output perm_dbg_t  dbg_o
);

   perm_state_e state_q;
   logic [3:0]  round_q;
   logic [4:0]  round_nxt;
   state_t      round_out;

   // UNROLL chained rounds: pc inline, then ps, then pl.
   for (genvar u = 0; u < UNROLL; u++) begin : g_round
      state_t s_in, pc_s, ps_s, s_out;

      if (u == 0) begin : g_first
         assign s_in = S_o;
      end else begin : g_next
         assign s_in = g_round[u-1].s_out;
      end

      always_comb begin
         pc_s            = s_in;
         pc_s[X2 +: 64]  = s_in[X2 +: 64] ^ ascon_rc(round_q + 4'(u));
      end

      ascon_ps u_ps (.s_i(pc_s), .s_o(ps_s));
      ascon_pl u_pl (.s_i(ps_s), .s_o(s_out));

      if (u == UNROLL - 1) begin : g_last
         assign round_out = s_out;
      end
   end

   assign round_nxt = {1'b0, round_q} + 5'(UNROLL);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         S_o     <= '0;
         round_q <= '0;
         busy_o  <= 1'b0;
         done_o  <= 1'b0;
         err_o   <= 1'b0;
      end else begin
         done_o <= 1'b0;
         err_o  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  if (nr_legal(nr_i, UNROLL)) begin
                     S_o     <= S_i;
                     // Short permutations use the last nr rounds of p12.
                     round_q <= 4'(ROUNDS_MAX) - nr_i;
                     state_q <= RUN;
                     busy_o  <= 1'b1;
                  end else begin
                     err_o <= 1'b1;
                  end
               end
            end
            RUN: begin
               S_o     <= round_out;
               round_q <= round_nxt[3:0];
               if (round_nxt >= 5'(ROUNDS_MAX)) begin
                  state_q <= IDLE;
                  busy_o  <= 1'b0;
                  done_o  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      dbg_o       = '0;
      dbg_o.state = state_q;
      dbg_o.round = round_q;
      dbg_o.rc    = ascon_rc(round_q);
   end

endmodule

// File: tb/tb_ascon_perm.sv
// Bench for ascon_perm: three instances (UNROLL = 1, 2, 4) share clock, reset,
// round count and input state; each has its own start. Expected states come
// from a table-driven reference model of the Ascon permutation.
module tb_ascon_perm;
   import ascon_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [2:0]  start_a;
   logic [3:0]  nr;
   state_t      s_in;
   state_t      so_a [3];
   logic [2:0]  busy_a, done_a, err_a;
   perm_dbg_t   dbg_a [3];

   int n_cmp  = 0;
   int n_fail = 0;
   logic [319:0] exp_q [$];

   localparam logic [319:0] VEC_A = {5{64'hfeedfacecafebeef}};
   localparam logic [319:0] VEC_B = {64'h0123456789abcdef, 64'h0, 64'hffffffffffffffff,
                                     64'h1, 64'h8000000000000000};

   ascon_perm #(.UNROLL(1)) u1 (
      .clk_i(clk), .rst_i(rst), .start_i(start_a[0]), .nr_i(nr), .S_i(s_in),
      .S_o(so_a[0]), .busy_o(busy_a[0]), .done_o(done_a[0]), .err_o(err_a[0]), .dbg_o(dbg_a[0]));
   ascon_perm #(.UNROLL(2)) u2 (
      .clk_i(clk), .rst_i(rst), .start_i(start_a[1]), .nr_i(nr), .S_i(s_in),
      .S_o(so_a[1]), .busy_o(busy_a[1]), .done_o(done_a[1]), .err_o(err_a[1]), .dbg_o(dbg_a[1]));
   ascon_perm #(.UNROLL(4)) u4 (
      .clk_i(clk), .rst_i(rst), .start_i(start_a[2]), .nr_i(nr), .S_i(s_in),
      .S_o(so_a[2]), .busy_o(busy_a[2]), .done_o(done_a[2]), .err_o(err_a[2]), .dbg_o(dbg_a[2]));

   // ---------------- reference model ----------------
   localparam logic [4:0] SBOX [32] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

   function automatic logic [63:0] ref_ror(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   function automatic logic [319:0] ref_perm(input logic [319:0] s, input int rounds);
      logic [63:0] x [5];
      logic [63:0] y [5];
      logic [4:0]  col;
      logic [4:0]  o;
      for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
      for (int r = 12 - rounds; r < 12; r++) begin
         x[2] = x[2] ^ {56'd0, 4'(15 - r), 4'(r)};
         for (int b = 0; b < 64; b++) begin
            col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
            o   = SBOX[col];
            for (int i = 0; i < 5; i++) y[i][b] = o[4 - i];
         end
         x[0] = y[0] ^ ref_ror(y[0], 19) ^ ref_ror(y[0], 28);
         x[1] = y[1] ^ ref_ror(y[1], 61) ^ ref_ror(y[1], 39);
         x[2] = y[2] ^ ref_ror(y[2], 1)  ^ ref_ror(y[2], 6);
         x[3] = y[3] ^ ref_ror(y[3], 10) ^ ref_ror(y[3], 17);
         x[4] = y[4] ^ ref_ror(y[4], 7)  ^ ref_ror(y[4], 41);
      end
      return {x[0], x[1], x[2], x[3], x[4]};
   endfunction

   // ---------------- driver ----------------
   // Pulses start on instance k, then watches at negedges until done_o.
   // Returns to the caller at the negedge where done_o was seen.
   task automatic drive_perm(input int k, input logic [3:0] n, output int busy_cyc,
                             output state_t res, output logic [63:0] rc0, output bit to);
      nr = n;
      start_a[k] = 1'b1;
      @(posedge clk); #1;
      start_a[k] = 1'b0;
      busy_cyc = 0;
      to       = 1'b1;
      rc0      = '0;
      res      = '0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (c == 0) rc0 = dbg_a[k].rc;
         if (done_a[k]) begin
            to  = 1'b0;
            res = so_a[k];
            break;
         end
         if (busy_a[k]) busy_cyc++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #3 rst = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (so_a[k] !== '0) begin
            n_fail++; $display("FAIL reset_state[%0d]: got %h want 0", k, so_a[k]);
         end
         n_cmp++;
         if ({busy_a[k], done_a[k], err_a[k]} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags[%0d]: got %b want 000", k, {busy_a[k], done_a[k], err_a[k]});
         end
         n_cmp++;
         if (dbg_a[k].state !== IDLE || dbg_a[k].round !== 4'd0) begin
            n_fail++; $display("FAIL reset_dbg[%0d]: got state %0d round %0d want 0 0", k, dbg_a[k].state, dbg_a[k].round);
         end
      end
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_perm_u1(input logic [3:0] n, input logic [63:0] rc_want, input string tag);
      int busy_cyc; state_t res; logic [63:0] rc0; bit to; logic [319:0] want;
      s_in = VEC_A;
      exp_q.push_back(ref_perm(VEC_A, int'(n)));
      drive_perm(0, n, busy_cyc, res, rc0, to);
      n_cmp++;
      if (to) begin
         n_fail++; $display("FAIL %s_timeout: no done_o within 40 cycles", tag);
      end
      n_cmp++;
      if (busy_cyc !== int'(n)) begin
         n_fail++; $display("FAIL %s_latency: got %0d busy cycles want %0d", tag, busy_cyc, n);
      end
      n_cmp++;
      if (rc0 !== rc_want) begin
         n_fail++; $display("FAIL %s_first_rc: got %h want %h", tag, rc0, rc_want);
      end
      want = exp_q.pop_front();
      n_cmp++;
      if (res !== want) begin
         n_fail++; $display("FAIL %s_state: got %h want %h", tag, res, want);
      end
      n_cmp++;
      if (busy_a[0] !== 1'b0) begin
         n_fail++; $display("FAIL %s_busy_at_done: got %b want 0", tag, busy_a[0]);
      end
      @(negedge clk);
      n_cmp++;
      if (done_a[0] !== 1'b0 || so_a[0] !== want) begin
         n_fail++; $display("FAIL %s_after_done: got done %b state %h want done 0 state %h", tag, done_a[0], so_a[0], want);
      end
   endtask

   task automatic test_p12();
      test_perm_u1(4'd12, 64'hF0, "p12");
   endtask

   task automatic test_p8();
      test_perm_u1(4'd8, 64'hB4, "p8");
   endtask

   task automatic test_illegal();
      int          ks [3] = '{0, 0, 2};
      logic [3:0]  ns [3] = '{4'd0, 4'd13, 4'd6};
      state_t      prev;
      for (int i = 0; i < 3; i++) begin
         prev = so_a[ks[i]];
         nr = ns[i];
         start_a[ks[i]] = 1'b1;
         @(posedge clk); #1;
         start_a[ks[i]] = 1'b0;
         @(negedge clk);
         n_cmp++;
         if ({err_a[ks[i]], busy_a[ks[i]], done_a[ks[i]]} !== 3'b100) begin
            n_fail++; $display("FAIL illegal_nr%0d_flags: got err/busy/done %b want 100", ns[i], {err_a[ks[i]], busy_a[ks[i]], done_a[ks[i]]});
         end
         n_cmp++;
         if (so_a[ks[i]] !== prev || dbg_a[ks[i]].state !== IDLE) begin
            n_fail++; $display("FAIL illegal_nr%0d_state: got %h want %h (idle)", ns[i], so_a[ks[i]], prev);
         end
         @(negedge clk);
         n_cmp++;
         if (err_a[ks[i]] !== 1'b0 || busy_a[ks[i]] !== 1'b0) begin
            n_fail++; $display("FAIL illegal_nr%0d_clear: got err %b busy %b want 0 0", ns[i], err_a[ks[i]], busy_a[ks[i]]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int dones = 0; int errs = 0; int first = -1; int second = -1;
      logic [319:0] want;
      s_in = VEC_A;
      nr   = 4'd8;
      exp_q.push_back(ref_perm(VEC_A, 8));
      start_a[0] = 1'b1;
      @(posedge clk); #1;
      // Changes while running must not matter; they become the second request.
      s_in = VEC_B;
      nr   = 4'd12;
      exp_q.push_back(ref_perm(VEC_B, 12));
      for (int c = 0; c < 60 && dones < 2; c++) begin
         @(negedge clk);
         if (err_a[0]) errs++;
         if (done_a[0]) begin
            dones++;
            if (dones == 1) first = c; else second = c;
            want = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            n_cmp++;
            if (so_a[0] !== want) begin
               n_fail++; $display("FAIL b2b_state%0d: got %h want %h", dones, so_a[0], want);
            end
         end
         if (dones == 1 && c == first + 1) begin
            n_cmp++;
            if (busy_a[0] !== 1'b1 || done_a[0] !== 1'b0) begin
               n_fail++; $display("FAIL b2b_accept: got busy %b done %b want 1 0", busy_a[0], done_a[0]);
            end
            start_a[0] = 1'b0;
         end
      end
      start_a[0] = 1'b0;
      n_cmp++;
      if (dones !== 2 || errs !== 0) begin
         n_fail++; $display("FAIL b2b_pulses: got %0d done %0d err want 2 0", dones, errs);
      end
      n_cmp++;
      if (second - first !== 13) begin
         n_fail++; $display("FAIL b2b_spacing: got %0d cycles want 13", second - first);
      end
      exp_q.delete();
   endtask

   task automatic test_reset_mid_run();
      int cnt = 0; int dones = 0;
      s_in = VEC_A;
      nr   = 4'd12;
      start_a[0] = 1'b1;
      @(posedge clk); #1;
      start_a[0] = 1'b0;
      for (int c = 0; c < 20 && cnt < 5; c++) begin
         @(negedge clk);
         if (busy_a[0]) cnt++;
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (so_a[0] !== '0 || busy_a[0] !== 1'b0 || done_a[0] !== 1'b0 || dbg_a[0].state !== IDLE) begin
         n_fail++; $display("FAIL midrun_reset: got state %h busy %b done %b want 0 0 0", so_a[0], busy_a[0], done_a[0]);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (done_a[0]) dones++;
      end
      n_cmp++;
      if (dones !== 0 || busy_a[0] !== 1'b0) begin
         n_fail++; $display("FAIL midrun_no_done: got %0d done pulses busy %b want 0 0", dones, busy_a[0]);
      end
   endtask

   task automatic test_unroll();
      int busy_cyc; state_t res; logic [63:0] rc0; bit to; logic [319:0] want;
      int lat_want [3] = '{12, 6, 3};
      for (int k = 1; k < 3; k++) begin
         s_in = VEC_A;
         exp_q.push_back(ref_perm(VEC_A, 12));
         drive_perm(k, 4'd12, busy_cyc, res, rc0, to);
         n_cmp++;
         if (to || busy_cyc !== lat_want[k]) begin
            n_fail++; $display("FAIL unroll%0d_latency: got %0d busy cycles (timeout %0d) want %0d", 1 << k, busy_cyc, to, lat_want[k]);
         end
         n_cmp++;
         if (rc0 !== 64'hF0) begin
            n_fail++; $display("FAIL unroll%0d_first_rc: got %h want f0", 1 << k, rc0);
         end
         want = exp_q.pop_front();
         n_cmp++;
         if (res !== want) begin
            n_fail++; $display("FAIL unroll%0d_state: got %h want %h", 1 << k, res, want);
         end
         @(negedge clk);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst     = 1'b0;
      start_a = '0;
      nr      = '0;
      s_in    = '0;
      test_reset();
      test_p12();
      test_p8();
      test_illegal();
      test_back_to_back();
      test_reset_mid_run();
      test_unroll();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/ascon_perm.md
# ascon_perm

Iterative Ascon permutation core: loads a 320-bit state, applies `nr_i` rounds, and returns the permuted state with a one-cycle completion pulse. Each round is constant addition (pc), then the substitution layer (ps), then the existing linear diffusion layer `ascon_pl`. `UNROLL` rounds are evaluated per clock. The AEAD128a mode controller uses this core for p12 (init/final) and p8 (data blocks).

## Interface
- `UNROLL`, default 1: rounds computed per clock; legal values are 1, 2 and 4.
- `clk_i`  in  1  clock; all state changes on its rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `start_i`  in  1  request; sampled only while `busy_o`=0.
- `nr_i`  in  4  round count for the request.
- `S_i`  in  320  input state. Word layout: x0=[319:256], x1=[255:192], x2=[191:128], x3=[127:64], x4=[63:0].
- `S_o`  out  320  state register, with the same word layout.
- `busy_o`  out  1  permutation in progress.
- `done_o`  out  1  one-cycle pulse: `S_o` holds the final state.
- `err_o`  out  1  one-cycle pulse: the request was rejected.

## Operation
- States: IDLE and RUN. Reset values: state IDLE, `S_o`=0, `busy_o`=0, `done_o`=0, `err_o`=0, round index=0.
- **Legal `nr_i`:** 1..12 and a multiple of `UNROLL`.
- **Illegal request:** `start_i`=1 with an illegal `nr_i` in IDLE.
  - `err_o`=1 for the next cycle.
  - State, `S_o` and `busy_o` are unchanged.
- **Legal start** (IDLE):
  - Load `S_o`<=`S_i` and round index r<=12-`nr_i`.
  - Go to RUN, `busy_o`<=1.
- **Round index r:** constant c_r = {4'hF - r[3:0], r[3:0]}, zero-extended to 64 bits, XORed into x2.
  - r=0 gives 0xF0; r=4 gives 0xB4.
- **Substitution layer:** the Ascon 5-bit S-box is applied bit-sliced across the five words for each of the 64 columns.
- **RUN, each edge:**
  - Apply UNROLL rounds with indices r..r+UNROLL-1; update `S_o`; r<=r+UNROLL.
  - When the new r reaches 12: go to IDLE, `busy_o`<=0, `done_o`<=1.
- `done_o` and `err_o` self-clear after one cycle.
- `S_o` stays stable in IDLE until the next legal start.
- **`start_i` during RUN:** ignored, with no error pulse.
- **Start in the done cycle:** a legal start in the cycle where `done_o`=1 is accepted. `done_o` drops and `busy_o` rises on the following edge.
- **Reset mid-RUN:** immediate return to reset values; no `done_o`.

## Timing
- **Latency:** a legal start sampled at edge k gives `done_o`=1 and `busy_o`=0 in the cycle after edge k + `nr_i`/UNROLL.
  - UNROLL=1, p12: 12 cycles busy. p8: 8 cycles.
  - UNROLL=4, p12: 3 cycles.
- **Back-to-back throughput:** one permutation every `nr_i`/UNROLL + 1 cycles.
- **Error timing:** `err_o` asserts in the cycle after the rejected start.
- **Path structure:** all outputs are registered. The combinational path is UNROLL chained rounds, register to register. No input-to-output combinational path.

## Structure
- **Package `ascon_pkg`:**
  - `state_t` (logic [319:0]).
  - Word slice constants X0..X4.
  - `ROUNDS_MAX`=12.
  - Function `ascon_rc(r)` returning c_r.
  - Function `nr_legal(nr, unroll)`.
- **New sub-module `ascon_ps`:** combinational 320-in/320-out substitution layer, sitting directly upstream of `ascon_pl`.
- **One round:** pc inline, then `ascon_ps`, then `ascon_pl`. UNROLL copies are chained with a generate loop.
- **Top level:** holds the FSM, round index and state register.

## Test plan
- **Reset:** assert `rst_i` asynchronously mid-clock.
  - `S_o`=0, `busy_o`=0, `done_o`=0 immediately.
- **p12:** UNROLL=1, `S_i`=feedfacecafebeef repeated 5×, `nr_i`=12, start.
  - `busy_o` is high for exactly 12 cycles, then `done_o` pulses once.
  - `S_o` equals the Ascon reference-model p12 output.
  - First-round constant 0xF0 is visible in x2 via the internal probe.
- **p8:** same state, `nr_i`=8.
  - `done_o` after 8 busy cycles; `S_o` matches reference p8; first constant 0xB4.
- **Illegal requests:** `nr_i`=0, then 13, then (with UNROLL=4) 6.
  - Each gives an `err_o` pulse only; `busy_o` stays 0 and `S_o` is unchanged.
- **Back-to-back and ignored start:** legal start asserted in the `done_o` cycle, plus `start_i` held high throughout RUN.
  - Second run accepted immediately; mid-RUN starts ignored; two `done_o` pulses total.
- **Reset mid-run and UNROLL=2/4:** reset at busy cycle 5 aborts with no `done_o`. Repeating the p12 vector with UNROLL=2 and 4 gives latencies 6 and 3 and identical `S_o`.
